// File: rtl/sseg_scan_decoder.sv
// ============================================================================
// Module      : sseg_scan_decoder
// Description : Decodes a scanned 4-digit 7-segment bus back into a signed
//               9-bit value. Optional macro SSEG_DECODE_CHANGE_ONLY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] SSeg,
  input  logic [3:0] an,
  output logic [8:0] resultado,
  output logic       valid,
  output logic       err,
  output logic       stale
);

  localparam int c_SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_SET_W-1:0] c_SETTLE_SAT  = c_SET_W'(SETTLE_CYCLES);
  localparam logic [c_TO_W-1:0]  c_TO_MAX      = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [6:0]         c_SEG_DASH    = 7'b0111111;
  localparam logic [6:0]         c_SEG_BLANK   = 7'b1111111;

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_ASSEMBLE = 2'd1,
    S_CHECK    = 2'd2
  } state_t;

  // {invalid, value}
  function automatic logic [4:0] f_digit(input logic [6:0] seg);
    case (seg)
      7'b1000000: f_digit = 5'd0;
      7'b1111001: f_digit = 5'd1;
      7'b0100100: f_digit = 5'd2;
      7'b0110000: f_digit = 5'd3;
      7'b0011001: f_digit = 5'd4;
      7'b0010010: f_digit = 5'd5;
      7'b0000010: f_digit = 5'd6;
      7'b1111000: f_digit = 5'd7;
      7'b0000000: f_digit = 5'd8;
      7'b0010000: f_digit = 5'd9;
      default:    f_digit = 5'b1_0000;
    endcase
  endfunction

  logic [3:0]         r_an_meta, r_an_sync;
  logic [6:0]         r_seg_meta, r_seg_sync;
  logic [10:0]        r_prev;
  logic [c_SET_W-1:0] r_stab_cnt;

  state_t             r_state;
  logic [3:0]         r_seen;
  logic [3:0]         r_dig_u, r_dig_t, r_dig_h;
  logic [3:0]         r_inv;
  logic               r_neg;
  logic [9:0]         r_mag;
  logic               r_neg_q, r_bad_q;
  logic [8:0]         r_resultado;
  logic               r_valid, r_err;
  logic [c_TO_W-1:0]  r_to_cnt;

  logic               w_same, w_capture, w_onehot, w_multi;
  logic [3:0]         w_an_low;
  logic [4:0]         w_dig;
  logic               w_sign_dash, w_sign_blank;
  logic [3:0]         w_seen_base, w_seen_next;
  logic [9:0]         w_mag;
  logic               w_chk_bad, w_good_frame, w_pulse;
  logic [8:0]         w_new_val;

  assign w_same    = ({r_an_sync, r_seg_sync} == r_prev);
  assign w_capture = (r_stab_cnt == c_SETTLE_LAST);
  assign w_an_low  = ~r_prev[10:7];
  assign w_onehot  = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
  assign w_multi   = (w_an_low != 4'd0) && !w_onehot;
  assign w_dig        = f_digit(r_prev[6:0]);
  assign w_sign_dash  = (r_prev[6:0] == c_SEG_DASH);
  assign w_sign_blank = (r_prev[6:0] == c_SEG_BLANK);

  // seen is cleared in CHECK before that cycle's capture is merged in.
  always_comb begin
    w_seen_base = (r_state == S_CHECK) ? 4'd0 : r_seen;
    w_seen_next = w_seen_base;
    if (w_capture) begin
      if (w_multi)
        w_seen_next = 4'd0;
      else if (w_onehot)
        w_seen_next = w_seen_base | w_an_low;
    end
  end

  // 100h + 10t + u with shifts and adds only
  assign w_mag = {r_dig_h, 6'b0} + {1'b0, r_dig_h, 5'b0} + {4'b0, r_dig_h, 2'b0}
               + {3'b0, r_dig_t, 3'b0} + {5'b0, r_dig_t, 1'b0} + {6'b0, r_dig_u};

  assign w_chk_bad = r_bad_q
                   || ( r_neg_q && (r_mag == 10'd0))
                   || (!r_neg_q && (r_mag > 10'd255))
                   || ( r_neg_q && (r_mag > 10'd256));
  assign w_new_val    = r_neg_q ? (9'd0 - r_mag[8:0]) : r_mag[8:0];
  assign w_good_frame = (r_state == S_CHECK) && !w_chk_bad;

`ifdef SSEG_DECODE_CHANGE_ONLY_EN
  assign w_pulse = (w_new_val != r_resultado);
`else
  assign w_pulse = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_meta  <= 4'hF;
      r_an_sync  <= 4'hF;
      r_seg_meta <= 7'h7F;
      r_seg_sync <= 7'h7F;
      r_prev     <= 11'h7FF;
      r_stab_cnt <= '0;
    end else begin
      r_an_meta  <= an;
      r_an_sync  <= r_an_meta;
      r_seg_meta <= SSeg;
      r_seg_sync <= r_seg_meta;
      r_prev     <= {r_an_sync, r_seg_sync};
      // Saturating past the capture point makes each stable slot latch once.
      if (!w_same)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != c_SETTLE_SAT)
        r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_seen      <= 4'd0;
      r_dig_u     <= 4'd0;
      r_dig_t     <= 4'd0;
      r_dig_h     <= 4'd0;
      r_inv       <= 4'd0;
      r_neg       <= 1'b0;
      r_mag       <= 10'd0;
      r_neg_q     <= 1'b0;
      r_bad_q     <= 1'b0;
      r_resultado <= 9'd0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_seen  <= w_seen_next;
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_capture && w_onehot) begin
        case (w_an_low)
          4'b0001: begin r_dig_u <= w_dig[3:0]; r_inv[0] <= w_dig[4]; end
          4'b0010: begin r_dig_t <= w_dig[3:0]; r_inv[1] <= w_dig[4]; end
          4'b0100: begin r_dig_h <= w_dig[3:0]; r_inv[2] <= w_dig[4]; end
          4'b1000: begin
            r_neg    <= w_sign_dash;
            r_inv[3] <= !(w_sign_dash || w_sign_blank);
          end
          default: ;
        endcase
      end

      case (r_state)
        S_COLLECT: begin
          if (w_seen_next == 4'b1111)
            r_state <= S_ASSEMBLE;
        end
        S_ASSEMBLE: begin
          // Snapshot so captures for the next frame cannot disturb CHECK.
          r_mag   <= w_mag;
          r_neg_q <= r_neg;
          r_bad_q <= |r_inv;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_chk_bad) begin
            r_err <= 1'b1;
          end else if (w_pulse) begin
            r_valid     <= 1'b1;
            r_resultado <= w_new_val;
          end
          r_state <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase

      if (w_good_frame)
        r_to_cnt <= '0;
      else if (r_to_cnt != c_TO_MAX)
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign resultado = r_resultado;
  assign valid     = r_valid;
  assign err       = r_err;
  assign stale     = (r_to_cnt == c_TO_MAX);

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
// ============================================================================
// Module      : tb_sseg_scan_decoder
// Description : Scoreboard bench for sseg_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sseg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] SSeg;
  logic [3:0] an;
  logic [8:0] resultado;
  logic       valid, err, stale;

  typedef struct packed {
    logic       is_err;
    logic [8:0] val;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] held = 9'd0;

  sseg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .SSeg     (SSeg),
    .an       (an),
    .resultado(resultado),
    .valid    (valid),
    .err      (err),
    .stale    (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1010101;
    endcase
  endfunction

  // Reference model of one complete frame
  task automatic model(input bit neg, input int h, input int t, input int u);
    int   mag;
    bit   bad;
    exp_t e;
    logic [8:0] v;
    mag = 100*h + 10*t + u;
    bad = (h < 0) || (t < 0) || (u < 0) || (neg && mag == 0)
       || (!neg && mag > 255) || (neg && mag > 256);
    if (bad) begin
      e.is_err = 1'b1; e.val = held; sb_q.push_back(e);
    end else begin
      v = neg ? 9'(512 - mag) : 9'(mag);
`ifdef SSEG_DECODE_CHANGE_ONLY_EN
      if (v != held) begin
        e.is_err = 1'b0; e.val = v; sb_q.push_back(e); held = v;
      end
`else
      e.is_err = 1'b0; e.val = v; sb_q.push_back(e); held = v;
`endif
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; SSeg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input bit neg, input int h, input int t, input int u);
    model(neg, h, t, u);
    drive(4'b0111, neg ? 7'b0111111 : 7'b1111111, HOLD);
    drive(4'b1011, seg_of(h), HOLD);
    drive(4'b1101, seg_of(t), HOLD);
    drive(4'b1110, seg_of(u), HOLD);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 300) begin
      @(posedge clk); k++;
    end
    #1;
    check("drain_pending", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    held = 9'd0;
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1 && (valid || err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, valid, err}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", {30'b0, valid, err}, mon_e.is_err ? 32'd1 : 32'd2);
        check("resultado", {23'b0, resultado}, {23'b0, mon_e.val});
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; an = 4'hF; SSeg = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resultado", {23'b0, resultado}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_stale", {31'b0, stale}, 32'd0);
    rst = 1'b0;

    // Basic positive and negative frames, including -256 boundary
    scan(0, 0, 4, 2);
    scan(1, 1, 2, 8);
    scan(1, 2, 5, 6);
    wait_drain();

    // Rejected frames: -0, 260, -257, bad digit code
    scan(1, 0, 0, 0);
    scan(0, 2, 6, 0);
    scan(1, 2, 5, 7);
    scan(0, -1, 4, 2);
    scan(0, 2, 5, 5);
    wait_drain();

    // Fast toggling never settles; stale rises at TIMEOUT
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, seg_of(0), 2);
      drive(4'b1101, seg_of(1), 2);
    end
    check("stale_early", {31'b0, stale}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, seg_of(0), 2);
      drive(4'b1101, seg_of(1), 2);
    end
    check("stale_timeout", {31'b0, stale}, 32'd1);
    scan(0, 0, 4, 2);
    wait_drain();
    check("stale_cleared", {31'b0, stale}, 32'd0);

    // Multiple anodes low restarts the frame without an error
    model(0, 0, 0, 7);
    drive(4'b0111, 7'b1111111, HOLD);
    drive(4'b1011, seg_of(0), HOLD);
    drive(4'b1101, seg_of(0), HOLD);
    drive(4'b1100, seg_of(5), HOLD);
    drive(4'b1110, seg_of(7), HOLD);
    check("no_early_valid", sb_q.size(), 1);
    drive(4'b0111, 7'b1111111, HOLD);
    drive(4'b1011, seg_of(0), HOLD);
    drive(4'b1101, seg_of(0), HOLD);
    wait_drain();

    // Repeated identical frames
    scan(0, 0, 4, 2);
    scan(0, 0, 4, 2);
    scan(0, 0, 4, 2);
    wait_drain();

    // Reset mid-frame discards the partial frame
    drive(4'b0111, 7'b1111111, HOLD);
    drive(4'b1011, seg_of(0), HOLD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_resultado", {23'b0, resultado}, 32'd0);
    check("mid_rst_valid", {31'b0, valid}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    check("mid_rst_stale", {31'b0, stale}, 32'd0);
    rst = 1'b0;
    held = 9'd0;
    sb_q.delete();
    drive(4'b1101, seg_of(4), HOLD);
    drive(4'b1110, seg_of(2), HOLD);
    drive(4'b1111, 7'b1111111, 20);
    check("mid_rst_no_output", {23'b0, resultado}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
